// File: rtl/hdlverifier_data_jtag_wr_pkg.sv
// Shared definitions for the JTAG data engines: FSM state encoding and chunk-length decode.
package hdlverifier_data_jtag_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A chunk size of zero encodes a full buffer (2**aw words).
  function automatic int unsigned chunk_len(input int unsigned size, input int unsigned aw);
    return (size == 0) ? (32'd1 << aw) : size;
  endfunction

endpackage

// File: rtl/hdlverifier_serial_deser.sv
// LSB-first serial-to-parallel shift register with bit counter.
module hdlverifier_serial_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int BW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  shift_bit,
  output logic [BW-1:0]         bit_cnt,
  output logic [DATA_WIDTH-1:0] word_next
);

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]         cnt_q, cnt_d;

  assign word_next = {shift_bit, sreg_q[DATA_WIDTH-1:1]};
  assign bit_cnt   = cnt_q;

  // Clear and shift together start a fresh word with this bit as its LSB.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
      if (shift_en) begin
        sreg_d = {shift_bit, {(DATA_WIDTH-1){1'b0}}};
        cnt_d  = BW'(1);
      end
    end else if (shift_en) begin
      sreg_d = word_next;
      cnt_d  = cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/hdlverifier_data_jtag_wr.sv
// JTAG-side host-to-FPGA deserializer: assembles serial bits into words and writes them
// into the stimulus buffer in host-armed chunks.
module hdlverifier_data_jtag_wr
  import hdlverifier_data_jtag_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_in_state,
  input  logic                  shift_in_en,
  input  logic                  shift_in_data,
  input  logic                  newChunk,
  input  logic [ADDR_WIDTH-1:0] chunkSize,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rdy_recv,
  output logic                  partial_word
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic                  seen_q, seen_d;
  logic                  rdy_q, rdy_d;
  logic                  partial_q, partial_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d;
  logic [CW-1:0]         chunk_len_q, chunk_len_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  deser_clear;
  logic                  deser_en;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  last_word;
  logic                  word_done;

  hdlverifier_serial_deser #(
    .DATA_WIDTH (DATA_WIDTH),
    .BW         (BW)
  ) u_deser (
    .clk       (clk),
    .reset     (reset),
    .clear     (deser_clear),
    .shift_en  (deser_en),
    .shift_bit (shift_in_data),
    .bit_cnt   (bit_cnt),
    .word_next (word_next)
  );

  assign last_word   = (word_cnt_q + CW'(1)) == chunk_len_q;
  // The WRITE cycle keeps accepting bits unless it carries the final word of the chunk.
  assign deser_en    = shift_in_en && shift_in_state &&
                       ((state_q == ST_SHIFT) || (state_q == ST_WRITE && !last_word));
  assign deser_clear = (state_q != ST_SHIFT);
  assign word_done   = (state_q == ST_SHIFT) && deser_en && (bit_cnt == BW'(DATA_WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seen_q      <= newChunk;
      rdy_q       <= 1'b1;
      partial_q   <= 1'b0;
      word_cnt_q  <= '0;
      chunk_len_q <= '0;
      waddr_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      rdy_q       <= rdy_d;
      partial_q   <= partial_d;
      word_cnt_q  <= word_cnt_d;
      chunk_len_q <= chunk_len_d;
      waddr_q     <= waddr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (newChunk != seen_q) state_d = ST_ARMED;
      ST_ARMED: if (shift_in_state) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!shift_in_state)  state_d = ST_ARMED;
        else if (word_done)   state_d = ST_WRITE;
      end
      ST_WRITE: state_d = last_word ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seen_d      = seen_q;
    rdy_d       = rdy_q;
    partial_d   = partial_q;
    word_cnt_d  = word_cnt_q;
    chunk_len_d = chunk_len_q;
    waddr_d     = waddr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (newChunk != seen_q) begin
          seen_d      = newChunk;
          rdy_d       = 1'b0;
          partial_d   = 1'b0;
          word_cnt_d  = '0;
          chunk_len_d = CW'(chunk_len(32'(chunkSize), ADDR_WIDTH));
        end
      end
      ST_SHIFT: begin
        if (!shift_in_state && bit_cnt != '0) partial_d = 1'b1;
        if (word_done) wr_data_d = word_next;
      end
      ST_WRITE: begin
        waddr_d    = waddr_q + ADDR_WIDTH'(1);
        word_cnt_d = word_cnt_q + CW'(1);
      end
      ST_DONE:  rdy_d = 1'b1;
      default: ;
    endcase
    wr           = (state_q == ST_WRITE);
    waddr        = waddr_q;
    wr_data      = wr_data_q;
    rdy_recv     = rdy_q;
    partial_word = partial_q;
  end

endmodule
